// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start/data/parity/stop recovery with one-cycle status pulses.
// Optional build macro UART_RX_MAJORITY_VOTE_EN selects 2-of-3 majority sampling around mid-bit.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic [2:0]            o_dbg_state
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                  r_state;
    logic                    r_rx_meta;
    logic                    r_rx_s;
    logic [PRESCALE_W-1:0]   r_p;
    logic [PRESCALE_W-1:0]   r_edge_cnt;
    logic [BW-1:0]           r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic                    r_par_flag;
    logic [DATA_WIDTH-1:0]   r_p_data;
    logic                    r_data_valid;
    logic                    r_par_err;
    logic                    r_stp_err;

    logic [PRESCALE_W-1:0]   w_p_even;
    logic [PRESCALE_W-1:0]   w_p_eff;
    logic [PRESCALE_W-1:0]   w_half;
    logic [PRESCALE_W-1:0]   w_edge_next;
    logic                    w_last;
    logic                    w_sample_pt;
    logic                    w_sample;
    logic                    w_unused;

    // Odd prescale values are rounded down so the mid-bit point is an exact integer.
    assign w_p_even    = {prescale[PRESCALE_W-1:1], 1'b0};
    assign w_p_eff     = (w_p_even < PRESCALE_W'(4)) ? PRESCALE_W'(4) : w_p_even;
    assign w_unused    = prescale[0];
    assign w_half      = {1'b0, r_p[PRESCALE_W-1:1]};
    assign w_last      = (r_edge_cnt == r_p - PRESCALE_W'(1));
    assign w_edge_next = w_last ? '0 : r_edge_cnt + PRESCALE_W'(1);

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] r_hist;

    // r_hist[0] holds rx_s at P/2 and r_hist[1] at P/2-1 when the decision is taken at P/2+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_rx_s};
        end
    end

    assign w_sample_pt = (r_edge_cnt == w_half + PRESCALE_W'(1));
    assign w_sample    = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_rx_s) | (r_hist[0] & r_rx_s);
`else
    assign w_sample_pt = (r_edge_cnt == w_half);
    assign w_sample    = r_rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RX_IN;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_p          <= PRESCALE_W'(4);
            r_edge_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_par_flag   <= 1'b0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state    <= S_START;
                        r_p        <= w_p_eff;
                        r_par_en   <= PAR_EN;
                        r_par_typ  <= PAR_TYP;
                        r_par_flag <= 1'b0;
                        r_edge_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                end
                S_START: begin
                    r_edge_cnt <= w_edge_next;
                    if (w_sample_pt && w_sample) begin
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_edge_cnt <= w_edge_next;
                    if (w_sample_pt) begin
                        r_shift <= {w_sample, r_shift[DATA_WIDTH-1:1]};
                    end
                    if (w_last) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    r_edge_cnt <= w_edge_next;
                    if (w_sample_pt) begin
                        r_par_flag <= (^r_shift) ^ w_sample ^ r_par_typ;
                    end
                    if (w_last) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    r_edge_cnt <= w_edge_next;
                    // Leave STOP at mid-bit so a start bit right after the stop bit is caught.
                    if (w_sample_pt) begin
                        r_stp_err <= ~w_sample;
                        r_par_err <= r_par_en & r_par_flag;
                        if (w_sample && !(r_par_en && r_par_flag)) begin
                            r_data_valid <= 1'b1;
                            r_p_data     <= r_shift;
                        end
                        r_state <= w_sample ? S_IDLE : S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign P_DATA      = r_p_data;
    assign data_valid  = r_data_valid;
    assign par_err     = r_par_err;
    assign stp_err     = r_stp_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: frames are pushed as expected events, a monitor pops on each pulse.
module tb_uart_rx_deserializer;

    logic       clk;
    logic       rst_n;
    logic       RX_IN;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic [2:0] o_dbg_state;

    // Expected event: {data_valid, par_err, stp_err, P_DATA}
    logic [10:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_pushed = 0;
    int n_seen   = 0;
    int bit_p    = 8;

    uart_rx_deserializer #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX_IN       (RX_IN),
        .prescale    (prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .o_dbg_state (o_dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget, got %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && (data_valid || par_err || stp_err)) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'({data_valid, par_err, stp_err, P_DATA}), 32'h0);
            end else begin
                chk("event", 32'({data_valid, par_err, stp_err, P_DATA}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic push_exp(input logic dv, input logic pe, input logic se, input logic [7:0] d);
        exp_q.push_back({dv, pe, se, d});
        n_pushed++;
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        RX_IN = b;
        repeat (bit_p) @(negedge clk);
    endtask

    task automatic send_data_bit(input logic b, input logic glitch);
        if (glitch) begin
            RX_IN = b;
            repeat (bit_p / 2) @(negedge clk);
            RX_IN = ~b;
            @(negedge clk);
            RX_IN = b;
            repeat (bit_p / 2 - 1) @(negedge clk);
        end else begin
            send_bit(b);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par_bit,
                              input logic stop_bit, input int toggle_at, input logic glitch,
                              input int gap);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == toggle_at) PAR_EN = ~PAR_EN;
            send_data_bit(d[i], glitch);
        end
        if (with_par) send_bit(par_bit);
        send_bit(stop_bit);
        idle(gap);
    endtask

    logic glitch_en;
    int   seen_before;

    initial begin
`ifdef UART_RX_MAJORITY_VOTE_EN
        glitch_en = 1'b1;
`else
        glitch_en = 1'b0;
`endif
        rst_n    = 1'b0;
        RX_IN    = 1'b1;
        prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        bit_p    = 8;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_dv", 32'(data_valid), 32'h0);
        chk("reset_pe", 32'(par_err), 32'h0);
        chk("reset_se", 32'(stp_err), 32'h0);
        chk("reset_pdata", 32'(P_DATA), 32'h0);
        chk("reset_state", 32'(o_dbg_state), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);

        // Plain 8N1 byte
        push_exp(1'b1, 1'b0, 1'b0, 8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, 1'b0, 20);

        // Reset in the middle of a data bit
        RX_IN = 1'b0;
        repeat (bit_p) @(negedge clk);
        RX_IN = 1'b1;
        repeat (bit_p) @(negedge clk);
        RX_IN = 1'b0;
        repeat (bit_p / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_dv", 32'(data_valid), 32'h0);
        chk("midreset_pe", 32'(par_err), 32'h0);
        chk("midreset_se", 32'(stp_err), 32'h0);
        chk("midreset_pdata", 32'(P_DATA), 32'h0);
        chk("midreset_state", 32'(o_dbg_state), 32'h0);
        RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen_before = n_seen;
        idle(100);
        chk("quiet_after_reset", 32'(n_seen), 32'(seen_before));

        // Even parity, good and bad parity bit
        prescale = 6'd16;
        bit_p    = 16;
        PAR_EN   = 1'b1;
        PAR_TYP  = 1'b0;
        push_exp(1'b1, 1'b0, 1'b0, 8'h8F);
        send_frame(8'h8F, 1'b1, 1'b1, 1'b1, -1, 1'b0, 40);
        push_exp(1'b0, 1'b1, 1'b0, 8'h8F);
        send_frame(8'h8F, 1'b1, 1'b0, 1'b1, -1, 1'b0, 40);

        // Stop bit sampled low
        prescale = 6'd8;
        bit_p    = 8;
        PAR_EN   = 1'b0;
        push_exp(1'b0, 1'b0, 1'b1, 8'h8F);
        send_frame(8'h9E, 1'b0, 1'b0, 1'b0, -1, 1'b0, 30);
        chk("after_break_state", 32'(o_dbg_state), 32'h0);

        // Short low glitch on idle line
        seen_before = n_seen;
        RX_IN = 1'b0;
        repeat (2) @(negedge clk);
        idle(30);
        chk("glitch_no_event", 32'(n_seen), 32'(seen_before));
        chk("glitch_state", 32'(o_dbg_state), 32'h0);

        // Back-to-back frames, no idle gap
        push_exp(1'b1, 1'b0, 1'b0, 8'h01);
        push_exp(1'b1, 1'b0, 1'b0, 8'hFE);
        send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1, 1'b0, 0);
        send_frame(8'hFE, 1'b0, 1'b0, 1'b1, -1, 1'b0, 30);

        // PAR_EN flips mid-frame; frame still decoded as no-parity
        push_exp(1'b1, 1'b0, 1'b0, 8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 2, glitch_en, 30);
        PAR_EN = 1'b0;

        idle(50);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        chk("event_count", 32'(n_seen), 32'(n_pushed));
        chk("final_pdata", 32'(P_DATA), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
